// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one async FIFO write port among NUM_REQ requesters.
// Optional admission control and post-packet GAP state enabled by `define FIFO_WR_ARB_ADMIT_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 16,
  parameter int MAX_PKT = 8
) (
  input  logic                                wr_clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0]           req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                fifo_wr_en,
  output logic [DWIDTH+$clog2(NUM_REQ):0]     fifo_wr_data,
  input  logic                                fifo_wr_full,
  input  logic [$clog2(DEPTH):0]              fifo_cnt_wr_synced,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                busy,
  output logic                                oversize_err
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BCW   = $clog2(MAX_PKT + 1);
  localparam logic [BCW-1:0] BEAT_MAX_C = BCW'(MAX_PKT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic             busy_q, busy_d;
  logic             oversize_q, oversize_d;
  logic [BCW-1:0]   beat_q, beat_d;
  logic             gap_q, gap_d;
  logic [IDW-1:0]   pick_s;
  logic             pick_vld_s;
  logic             admit_s;
  logic             fire_s;
  logic             last_s;
  logic [DWIDTH-1:0] data_s;

`ifdef FIFO_WR_ARB_ADMIT_EN
  // Admit only when a maximum-length packet is guaranteed to fit.
  localparam logic [CNT_W-1:0] ADMIT_LIMIT_C = CNT_W'(DEPTH - MAX_PKT);
  localparam state_t DONE_ST = GAP;
  assign admit_s = (fifo_cnt_wr_synced <= ADMIT_LIMIT_C);
`else
  localparam state_t DONE_ST = IDLE;
  logic unused_cnt_s;
  assign admit_s      = 1'b1;
  assign unused_cnt_s = ^fifo_cnt_wr_synced;
`endif

  // Round-robin pick: descending scan so the nearest requester after rr wins.
  always_comb begin
    logic [IDW:0] sum_v;
    pick_s     = '0;
    pick_vld_s = |req_valid;
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum_v = {1'b0, rr_q} + (IDW+1)'(i);
      if (sum_v >= (IDW+1)'(NUM_REQ)) begin
        sum_v = sum_v - (IDW+1)'(NUM_REQ);
      end else begin
        sum_v = sum_v;
      end
      if (req_valid[sum_v[IDW-1:0]]) begin
        pick_s = sum_v[IDW-1:0];
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Route the granted requester's beat onto the FIFO write bus.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_q) begin
        data_s = req_data[i*DWIDTH +: DWIDTH];
      end else begin
        data_s = data_s;
      end
    end
  end

  assign last_s       = req_last[grant_q];
  assign fire_s       = req_valid[grant_q] & ~fifo_wr_full;
  assign fifo_wr_data = {grant_q, last_s, data_s};
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign oversize_err = oversize_q;

  // Next-state, handshake and write-strobe logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    busy_d     = busy_q;
    oversize_d = oversize_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld_s && admit_s) begin
          grant_d = pick_s;
          busy_d  = 1'b1;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        req_ready[grant_q] = ~fifo_wr_full;
        fifo_wr_en         = fire_s;
        if (fire_s && last_s) begin
          rr_d    = grant_q;
          beat_d  = '0;
          busy_d  = 1'b0;
          gap_d   = 1'b0;
          state_d = DONE_ST;
        end else if (fire_s) begin
          // Saturate the count; the packet keeps flowing past MAX_PKT.
          if (beat_q == BEAT_MAX_C) begin
            oversize_d = 1'b1;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end else begin
          state_d = XFER;
        end
      end
      GAP: begin
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= IDW'(NUM_REQ - 1);
      busy_q     <= 1'b0;
      oversize_q <= 1'b0;
      beat_q     <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      oversize_q <= oversize_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table plus write scoreboard.
// Also builds with FIFO_WR_ARB_ADMIT_EN defined, enabling the admission test.
module tb_fifo_wr_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int MAXP  = 8;
  localparam int IDW   = 2;
  localparam int FW    = DW + IDW + 1;
  localparam int CW    = 5;
`ifdef FIFO_WR_ARB_ADMIT_EN
  localparam int GAPN = 2;
`else
  localparam int GAPN = 0;
`endif

  logic               wr_clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid, req_last, req_ready;
  logic [NR*DW-1:0]   req_data;
  logic               fifo_wr_en;
  logic [FW-1:0]      fifo_wr_data;
  logic               fifo_wr_full;
  logic [CW-1:0]      fifo_cnt_wr_synced;
  logic [IDW-1:0]     grant_id;
  logic               busy, oversize_err;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .DEPTH(DEPTH), .MAX_PKT(MAXP)) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_cnt_wr_synced(fifo_cnt_wr_synced), .grant_id(grant_id), .busy(busy),
    .oversize_err(oversize_err)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic          full;
    logic [NR-1:0] rdy;
    logic          en;
    logic [IDW-1:0] g;
    logic          b;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] sb[$];
  vec_t tbl[$];
  int s_len[NR], s_beat[NR], s_pkts[NR], s_pno[NR];
  logic [NR-1:0] hs;

  function automatic logic [DW-1:0] dat(int id, int p, int b);
    return {8'(id), 8'(p), 16'(b)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (s_pkts[i] > 0);
      req_last[i]            = (s_beat[i] == s_len[i] - 1);
      req_data[i*DW +: DW]   = dat(i, s_pno[i], s_beat[i]);
    end
  endtask

  // Queue n packets of len beats on requester id; expected writes go in call order.
  task automatic load(input int id, input int len, input int n);
    for (int p = 0; p < n; p++)
      for (int b = 0; b < len; b++)
        sb.push_back({IDW'(id), (b == len - 1), dat(id, s_pno[id] + p, b)});
    s_len[id]  = len;
    s_beat[id] = 0;
    s_pkts[id] = n;
    drive();
  endtask

  task automatic sample();
    logic [FW-1:0] e;
    @(negedge wr_clk);
    if (fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_beat", fifo_wr_data, e);
      end
    end
  endtask

  task automatic tick();
    hs = req_valid & req_ready;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i] === 1'b1) begin
        if (s_beat[i] == s_len[i] - 1) begin
          s_beat[i] = 0;
          s_pkts[i]--;
          s_pno[i]++;
        end else begin
          s_beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  function automatic bit done();
    bit d = (sb.size() == 0);
    for (int i = 0; i < NR; i++) if (s_pkts[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic run_done(input string nm, input int budget);
    int n = 0;
    while (!done() && n < budget) begin
      cyc();
      n++;
    end
    chk({nm, "_complete"}, done(), 1);
  endtask

  initial begin
    int last_c, wn, k;
    rst = 1'b1;
    fifo_wr_full = 1'b0;
    fifo_cnt_wr_synced = '0;
    for (int i = 0; i < NR; i++) begin
      s_len[i] = 0; s_beat[i] = 0; s_pkts[i] = 0; s_pno[i] = 0;
    end
    drive();
    tick();
    tick();
    sample();
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_oversize", oversize_err, 0);
    chk("rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;

    // Test 1: all four send 2-beat packets at once; grants rotate 0..3.
    tbl.push_back('{1'b0, NR'(0), 1'b0, IDW'(0), 1'b0});
    for (int g = 0; g < NR; g++) begin
      repeat (2) tbl.push_back('{1'b0, NR'(1 << g), 1'b1, IDW'(g), 1'b1});
      repeat (GAPN + 1) tbl.push_back('{1'b0, NR'(0), 1'b0, IDW'(g), 1'b0});
    end
    for (int i = 0; i < NR; i++) load(i, 2, 1);
    for (int r = 0; r < tbl.size(); r++) begin
      fifo_wr_full = tbl[r].full;
      sample();
      chk("t1_ready", req_ready, tbl[r].rdy);
      chk("t1_wr_en", fifo_wr_en, tbl[r].en);
      chk("t1_grant", grant_id, tbl[r].g);
      chk("t1_busy", busy, tbl[r].b);
      tick();
    end
    chk("t1_all_written", done(), 1);
    repeat (4) cyc();

    // Test 2: full stalls requester 2 on its third beat while requester 0 waits.
    load(2, 5, 1);
    cyc();
    load(0, 1, 1);
    cyc();
    cyc();
    fifo_wr_full = 1'b1;
    repeat (4) begin
      sample();
      chk("t2_stall_wr_en", fifo_wr_en, 0);
      chk("t2_stall_ready", req_ready, 0);
      chk("t2_stall_grant", grant_id, 2);
      tick();
    end
    fifo_wr_full = 1'b0;
    run_done("t2", 20);
    repeat (4) cyc();

    // Test 3: requester 1 alone streaming single-beat packets.
    load(1, 1, 4);
    last_c = -1;
    wn = 0;
    for (int c = 0; c < 40 && !done(); c++) begin
      sample();
      if (fifo_wr_en === 1'b1) begin
        if (last_c >= 0) chk("t3_period", c - last_c, 2 + GAPN);
        chk("t3_grant", grant_id, 1);
        last_c = c;
        wn++;
      end
      tick();
    end
    chk("t3_writes", wn, 4);
    repeat (4) cyc();

    // Test 4: 10-beat packet from requester 3 trips the oversize flag on beat 8.
    load(3, 10, 1);
    k = 0;
    for (int c = 0; c < 40 && !done(); c++) begin
      sample();
      if (fifo_wr_en === 1'b1) begin
        chk("t4_oversize", oversize_err, (k >= 8));
        k++;
      end
      tick();
    end
    chk("t4_beats", k, 10);
    repeat (3) begin
      sample();
      chk("t4_sticky", oversize_err, 1);
      tick();
    end

    // Test 5: reset mid-packet abandons it and restores requester 0 priority.
    load(1, 1, 1);
    run_done("t5_pre", 10);
    repeat (4) cyc();
    load(2, 5, 1);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    s_pkts[2] = 0;
    s_beat[2] = 0;
    s_pno[2]++;
    sb.delete();
    load(0, 1, 1);
    load(3, 1, 1);
    sample();
    chk("t5_busy", busy, 0);
    chk("t5_wr_en", fifo_wr_en, 0);
    chk("t5_oversize", oversize_err, 0);
    chk("t5_grant_rst", grant_id, 0);
    tick();
    sample();
    chk("t5_regrant", grant_id, 0);
    chk("t5_regrant_busy", busy, 1);
    tick();
    run_done("t5", 20);
    repeat (4) cyc();

`ifdef FIFO_WR_ARB_ADMIT_EN
    // Test 6: occupancy 9 blocks admission; 8 admits on the following edge.
    fifo_cnt_wr_synced = CW'(9);
    load(0, 1, 2);
    repeat (4) begin
      sample();
      chk("t6_blocked_busy", busy, 0);
      chk("t6_blocked_ready", req_ready, 0);
      chk("t6_blocked_wr_en", fifo_wr_en, 0);
      tick();
    end
    fifo_cnt_wr_synced = CW'(8);
    sample();
    chk("t6_pre_grant", busy, 0);
    tick();
    sample();
    chk("t6_grant_busy", busy, 1);
    chk("t6_grant_id", grant_id, 0);
    last_c = -1;
    wn = 0;
    for (int c = 0; c < 20 && !done(); c++) begin
      if (c > 0) sample();
      if (fifo_wr_en === 1'b1) begin
        if (last_c >= 0) chk("t6_gap_period", c - last_c, 2 + GAPN);
        last_c = c;
        wn++;
      end else begin
        chk("t6_wait_ready", req_ready, 0);
      end
      tick();
    end
    chk("t6_writes", wn, 2);
    fifo_cnt_wr_synced = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
